// File: rtl/ecc_enc_stream.sv
// Streaming extended-Hamming (SECDED) encoder with one-shot error injection.
// Latency: LATENCY cycles (1 = output register, 2 = input + output register).
// Backpressure: each stage ready when empty or downstream ready; full throughput, no bubbles.
module ecc_enc_stream #(
    parameter int K       = 8,
    parameter int LATENCY = 1,
    parameter bit P0_LSB  = 1'b1,
    localparam int M0     = $clog2(K + 1),
    localparam int M      = ((1 << M0) >= (M0 + K + 1)) ? M0 : M0 + 1,
    localparam int N      = M + K
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [K-1:0] d_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N:0]   q_o,
    output logic         out_inj_o,
    input  logic         inj_req_i,
    input  logic [N:0]   inj_mask_i,
    output logic         inj_pending_o
);

    logic         src_vld;
    logic [K-1:0] src_dat;
    logic         stage_rdy;
    logic         out_rdy;
    logic         load;
    logic [N:0]   cw;
    logic [N:0]   enc;
    logic [N:0]   inj_mask;

    assign out_rdy    = !out_valid_o || out_ready_i;
    assign in_ready_o = rst_ni && stage_rdy;
    assign load       = src_vld && out_rdy;

    generate
        if (LATENCY == 2) begin : g_in_reg
            logic         s1_vld;
            logic [K-1:0] s1_dat;

            assign stage_rdy = !s1_vld || out_rdy;
            assign src_vld   = s1_vld;
            assign src_dat   = s1_dat;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s1_vld <= 1'b0;
                    s1_dat <= '0;
                end else if (stage_rdy) begin
                    s1_vld <= in_valid_i;
                    if (in_valid_i) begin
                        s1_dat <= d_i;
                    end
                end
            end
        end else begin : g_no_in_reg
            assign stage_rdy = out_rdy;
            assign src_vld   = in_valid_i;
            assign src_dat   = d_i;
        end
    endgenerate

    // Data fills non-power-of-two positions; parity at 2^i covers positions with bit i set.
    always_comb begin
        int  j;
        logic par;
        cw  = '0;
        j   = 0;
        par = 1'b0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = src_dat[j];
                j++;
            end
        end
        for (int i = 0; i < M; i++) begin
            par = 1'b0;
            for (int p = 1; p <= N; p++) begin
                if (p[i]) begin
                    par ^= cw[p];
                end
            end
            cw[1 << i] = par;
        end
        cw[0] = ^cw[N:1];
    end

    assign enc = P0_LSB ? cw : {cw[0], cw[N:1]};

    // The injection is consumed by the first load seen while already armed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o   <= 1'b0;
            q_o           <= '0;
            out_inj_o     <= 1'b0;
            inj_pending_o <= 1'b0;
            inj_mask      <= '0;
        end else begin
            if (load) begin
                out_valid_o <= 1'b1;
                q_o         <= enc ^ (inj_pending_o ? inj_mask : '0);
                out_inj_o   <= inj_pending_o;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            if (load && inj_pending_o) begin
                inj_pending_o <= 1'b0;
            end else if (inj_req_i && !inj_pending_o) begin
                inj_pending_o <= 1'b1;
                inj_mask      <= inj_mask_i;
            end
        end
    end

endmodule
